// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial stream, control and status bundle for prbs_checker.
//
// Stream handshake: bit_valid qualifies bit_in on each rising clk edge.
// There is no ready signal: the checker accepts every valid bit, one per
// clock, and the source must never expect backpressure.
//
// master: the stream source / status consumer.
// slave:  the checker itself.
interface prbs_checker_if #(
  parameter int ERR_W = 16
);
  // stream and control, driven by the source
  logic             clear;
  logic             bit_in;
  logic             bit_valid;

  // status, driven by the checker
  logic             locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic             stuck;
  logic [1:0]       fsm_state;  // debug view of the acquisition FSM

  modport master (
    output clear,
    output bit_in,
    output bit_valid,
    input  locked,
    input  mismatch,
    input  err_count,
    input  stuck,
    input  fsm_state
  );

  modport slave (
    input  clear,
    input  bit_in,
    input  bit_valid,
    output locked,
    output mismatch,
    output err_count,
    output stuck,
    output fsm_state
  );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising receive checker for the 32-bit Fibonacci
// LFSR stream (taps 31, 29, 25, 24, shift-left, new bit into bit 0).
//
// Acquisition runs FILL -> TRAIN -> LOCKED:
//   FILL   : load 32 received bits into the history, no compares.
//   TRAIN  : predict each bit, then shift the received bit in; a run of
//            LOCK_CNT correct predictions declares lock.
//   LOCKED : predict each bit and shift the prediction in (local reference
//            free-runs, so one bad bit produces exactly one error); a run of
//            UNLOCK_CNT mismatches drops back to FILL.
//
// Optional build macro: PRBS_CHK_STUCK_EN enables all-zero stream detection
// in TRAIN (sticky 'stuck' flag, zero stream can never lock). Without it
// 'stuck' is tied low and an all-zero stream locks like any other.
module prbs_checker #(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 8,
  parameter int ERR_W      = 16
) (
  input logic            clk,
  input logic            reset,
  prbs_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Run counters compare against "last" values so the counter only needs
  // to hold 0..CNT-1 and wraps to 0 on the transition itself.
  localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       UNLOCK_LAST = 8'(UNLOCK_CNT - 1);
  localparam logic [5:0]       FILL_LEN    = 6'd32;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [31:0]      hist_q, hist_d;
  logic [5:0]       fill_q, fill_d;
  logic [5:0]       fill_inc;
  logic [7:0]       run_q, run_d;
  logic [7:0]       miss_q, miss_d;

  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             pred;
  logic             hit;
  logic             zero_hold;
  logic             run_adv;
  logic             accept;

  // Prediction of the next stream bit from the history; bit 0 is newest.
  assign pred     = hist_q[31] ^ hist_q[29] ^ hist_q[25] ^ hist_q[24];
  assign hit      = (bus.bit_in == pred);
  assign accept   = bus.bit_valid;
  assign fill_inc = fill_q + 6'd1;

`ifdef PRBS_CHK_STUCK_EN
  // A zero bit on a zero history is "predicted" trivially; it must not
  // count toward lock, otherwise a dead link would look healthy.
  assign zero_hold = (bus.bit_in == 1'b0) && (hist_q == 32'd0);
`else
  assign zero_hold = 1'b0;
`endif

  assign run_adv = hit && !zero_hold;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; nothing moves on edges without an accepted bit.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        ST_FILL: begin
          if (fill_inc == FILL_LEN) begin
            state_d = ST_TRAIN;
          end
        end
        ST_TRAIN: begin
          if (run_adv && (run_q == LOCK_LAST)) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (!hit && (miss_q == UNLOCK_LAST)) begin
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  // Datapath next values: history shift source and the three run counters.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    run_d  = run_q;
    miss_d = miss_q;
    if (accept) begin
      case (state_q)
        ST_FILL: begin
          hist_d = {hist_q[30:0], bus.bit_in};
          fill_d = (fill_inc == FILL_LEN) ? 6'd0 : fill_inc;
          run_d  = 8'd0;
          miss_d = 8'd0;
        end
        ST_TRAIN: begin
          // self-sync: the received bit becomes part of the reference
          hist_d = {hist_q[30:0], bus.bit_in};
          miss_d = 8'd0;
          if (run_adv) begin
            run_d = (run_q == LOCK_LAST) ? 8'd0 : run_q + 8'd1;
          end else if (!hit) begin
            run_d = 8'd0;
          end
        end
        ST_LOCKED: begin
          // free-run: the prediction, not the received bit, is shifted in
          hist_d = {hist_q[30:0], pred};
          run_d  = 8'd0;
          if (!hit) begin
            if (miss_q == UNLOCK_LAST) begin
              miss_d = 8'd0;
              fill_d = 6'd0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = 8'd0;
          end
        end
        default: begin
          hist_d = hist_q;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 32'd0;
      fill_q <= 6'd0;
      run_q  <= 8'd0;
      miss_q <= 8'd0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      run_q  <= run_d;
      miss_q <= miss_d;
    end
  end

  // FSM output logic: next values of the registered status outputs.
  always_comb begin
    locked_d   = (state_d == ST_LOCKED);
    mismatch_d = accept && (state_q == ST_LOCKED) && !hit;
    err_d      = err_q;
    if (bus.clear) begin
      // clear wins over a same-cycle error, which is dropped
      err_d = '0;
    end else if (mismatch_d && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

`ifdef PRBS_CHK_STUCK_EN
  logic stuck_q, stuck_d;

  // Sticky all-zero flag: set by a zero bit on a zero history in TRAIN.
  always_comb begin
    stuck_d = stuck_q;
    if (bus.clear) begin
      stuck_d = 1'b0;
    end else if (accept && (state_q == ST_TRAIN) && zero_hold) begin
      stuck_d = 1'b1;
    end
  end

  // Stuck flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stuck_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
    end
  end

  assign bus.stuck = stuck_q;
`else
  assign bus.stuck = 1'b0;
`endif

  assign bus.locked    = locked_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_q;
  assign bus.fsm_state = state_q;

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receive-side checker for the 32-bit Fibonacci LFSR bit stream used by the hash/nonce random-sequence generator: polynomial taps 31, 29, 25, 24, shift-left, new bit into position 0, one output bit per clock. The block self-synchronises to an incoming bit stream and declares lock after a run of correct predictions. Once locked, it free-runs a local reference, flags every mismatching bit and counts errors. It sits on the verification/BIST path beside the generator, consuming its `seq[0]` output or any equivalent serial link.

## Interface
Parameters:
- `LOCK_CNT`, default 64: consecutive correct predictions in TRAIN required to enter LOCKED (1..255).
- `UNLOCK_CNT`, default 8: consecutive mismatches in LOCKED that force re-acquisition (1..255).
- `ERR_W`, default 16: width of the error counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `clear`  in  1  synchronous; zeroes `err_count` and `stuck`.
- `bit_in`  in  1  received stream bit.
- `bit_valid`  in  1  `bit_in` is accepted on this edge. No backpressure.
- `locked`  out  1  registered; high while in LOCKED.
- `mismatch`  out  1  registered one-cycle pulse per mismatching accepted bit in LOCKED.
- `err_count`  out  ERR_W  registered saturating mismatch count (LOCKED only).
- `stuck`  out  1  registered sticky all-zero-stream flag (see Configuration).

## Operation
- History register `hist[31:0]`: bit 0 holds the newest bit. Prediction `p = hist[31]^hist[29]^hist[25]^hist[24]`.
- States and behaviour, all actions only on edges where `bit_valid=1`:
  - FILL: shift `bit_in` into `hist`; a 6-bit fill counter counts to 32, then the block goes to TRAIN. No compares.
  - TRAIN: compare `bit_in` with `p`, then shift `bit_in` into `hist` (self-sync). A match increments the run counter; a mismatch zeroes it. When the run counter reaches `LOCK_CNT`, go to LOCKED and zero the run counter.
  - LOCKED: compare `bit_in` with `p`, then shift `p` (not `bit_in`) into `hist`, so there is no error multiplication.
    - Mismatch: pulse `mismatch`, increment `err_count` (saturating at all-ones), increment the miss-run counter.
    - Match: zero the miss-run counter.
    - Miss-run reaching `UNLOCK_CNT`: go to FILL and clear the fill counter.
- `bit_valid=0`: no state, history or counter change; `mismatch`=0.
- `clear` takes priority over a simultaneous increment: `err_count` becomes 0 and that cycle's error is dropped. `clear` does not affect lock state.
- Reset: state FILL, `hist`=0, all internal counters 0, `locked`=0, `mismatch`=0, `err_count`=0, `stuck`=0.

## Timing
- All outputs are registered. `mismatch` and the `err_count` update appear one cycle after the edge that accepts the offending bit.
- `locked` rises the cycle after acceptance of valid bit number 32+`LOCK_CNT` (96 by default) of an error-free stream.
- `locked` falls the cycle after acceptance of the `UNLOCK_CNT`-th consecutive mismatch. That bit still pulses `mismatch` and is counted.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first accepted bit after deassertion restarts FILL.
- Throughput: one bit per clock, sustained.

## Configuration
- `PRBS_CHK_STUCK_EN` defined:
  - In TRAIN, an accepted `bit_in=0` while `hist==0` does not advance the run counter, and `stuck` is set.
  - `stuck` stays set until `clear` or `reset`.
  - An all-zero stream can never lock.
- Not defined:
  - `stuck` is tied to 0.
  - An all-zero stream locks after 32+`LOCK_CNT` bits, because an LFSR predicts 0 from an all-zero history.

## Test plan
- Generator stream from reset seed 0x7FFFFFFF, 300 bits, `bit_valid`=1 continuously -> `locked` rises 1 cycle after the 96th bit; `err_count`=0; no `mismatch` pulses.
- Locked, invert one bit -> exactly one `mismatch` pulse; `err_count`=1; `locked` stays 1; the following bits produce no further mismatches.
- Locked, invert 8 consecutive bits -> `err_count`=8; `locked` falls after the 8th; the clean stream relocks after 96 further bits.
- Same stream with `bit_valid` high 1 cycle in 3 -> lock on the 96th accepted bit (about cycle 288); no spurious mismatches during the gaps.
- 200 zero bits -> with `PRBS_CHK_STUCK_EN`, `stuck`=1 and `locked`=0; without it, `locked`=1 after the 96th bit.
- `err_count` preset to 0xFFFF by errors, then an error -> `err_count` holds 0xFFFF. `clear` coincident with an error -> `err_count`=0. Async `reset` while locked -> all outputs 0 immediately.
